// File: rtl/binary_divider_4bits_seq_if.sv
// Operand/result bundle for the sequential divider.
// start/dividend/divisor flow master->slave; results and status flow back.
interface binary_divider_4bits_seq_if #(
  parameter int WIDTH = 4
) ();
  // start is a request, sampled only while the divider is not busy; no ready
  // back-pressure exists. The result is qualified by the one-cycle done pulse.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [1:0]       state_dbg;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, state_dbg
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, state_dbg
  );
endinterface

// File: rtl/binary_divider_4bits_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned operands.
// Division by zero completes in one cycle with an all-ones quotient.
module binary_divider_4bits_seq #(
  parameter int WIDTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  binary_divider_4bits_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // The partial remainder always ends below the divisor, so its top bit is
  // never set and only WIDTH bits are stored; the trial compare stays WIDTH+1.
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    trial  = {a_q, q_q[WIDTH-1]};
    fits   = (trial >= {1'b0, d_q});
    a_next = fits ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            a_d     = '0;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      S_RUN: begin
        a_d   = a_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = q_next;
          remainder_d = a_next;
          dbz_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_binary_divider_4bits_seq.sv
// Bench for binary_divider_4bits_seq: directed scenarios plus a full operand
// sweep, results predicted by an arithmetic model and held in exp_q.
module tb_binary_divider_4bits_seq;
  localparam int W = 4;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_divider_4bits_seq_if #(.WIDTH(W)) bus ();

  binary_divider_4bits_seq #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [2*W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(a, b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat counts edges after the accepting edge; called at a negedge.
  task automatic wait_done(input int lat0, output bit seen, output int lat, output int busy_n);
    seen = 1'b0;
    lat = lat0;
    busy_n = 0;
    while (lat < 20) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL reset_quotient got %0h exp 0", bus.quotient); end
    checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL reset_remainder got %0h exp 0", bus.remainder); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", bus.div_by_zero); end
    checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", bus.state_dbg, S_IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    issue(4'd13, 4'd3);
    wait_done(0, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || lat != W) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, W); end
    checks++; if (busy_n != W) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", busy_n, W); end
    checks++; if (got !== exp) begin errors++; $display("FAIL basic_13_3 got %h exp %h", got, exp); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", bus.done); end
    checks++; if ({bus.quotient, bus.remainder} !== exp[2*W-1:0]) begin errors++; $display("FAIL basic_hold got %h exp %h", {bus.quotient, bus.remainder}, exp[2*W-1:0]); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] tbl_a[4] = '{4'd15, 4'd0, 4'd3, 4'd15};
    logic [W-1:0] tbl_b[4] = '{4'd1, 4'd7, 4'd15, 4'd15};
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    for (int i = 0; i < 4; i++) begin
      issue(tbl_a[i], tbl_b[i]);
      wait_done(0, seen, lat, busy_n);
      exp = exp_q.pop_front();
      got = {bus.div_by_zero, bus.quotient, bus.remainder};
      checks++; if (!seen || got !== exp) begin errors++; $display("FAIL boundary_%0d_%0d got %h exp %h", tbl_a[i], tbl_b[i], got, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    issue(4'd9, 4'd0);
    wait_done(0, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || lat != 0) begin errors++; $display("FAIL dbz_latency got %0d exp 0", lat); end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL dbz_busy got %0d exp 0", busy_n); end
    checks++; if (got !== exp) begin errors++; $display("FAIL dbz_result got %h exp %h", got, exp); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dbz_done_width got %b exp 0", bus.done); end
  endtask

  task automatic test_ignore_busy();
    bit seen; int lat, busy_n, extra; logic [2*W:0] exp, got;
    issue(4'd13, 4'd3);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || lat != W) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", lat, W); end
    checks++; if (got !== exp) begin errors++; $display("FAIL ignore_result got %h exp %h", got, exp); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_done got %0d exp 0", extra); end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    drive(4'd13, 4'd3);
    @(negedge clk);
    bus.dividend = 4'd15; bus.divisor = 4'd4;
    exp_q.push_back(model(4'd15, 4'd4));
    wait_done(0, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL b2b_first got %h exp %h", got, exp); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b exp 1", bus.busy); end
    wait_done(0, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || lat != W) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, W); end
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_second got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    issue(4'd13, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (got !== '0) begin errors++; $display("FAIL midrst_outputs got %h exp 0", got); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_status got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL midrst_state got %0d exp %0d", bus.state_dbg, S_IDLE); end
    issue(4'd7, 4'd2);
    wait_done(0, seen, lat, busy_n);
    exp = exp_q.pop_front();
    got = {bus.div_by_zero, bus.quotient, bus.remainder};
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL midrst_7_2 got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    bit seen; int lat, busy_n; logic [2*W:0] exp, got;
    logic [W-1:0] a, b;
    for (int n = 0; n < 256 + 24; n++) begin
      if (n < 256) begin
        a = W'(n / 16); b = W'(n % 16);
      end else begin
        a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15));
      end
      issue(a, b);
      wait_done(0, seen, lat, busy_n);
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL sweep_queue_empty got 0 exp 1");
      end else begin
        exp = exp_q.pop_front();
        got = {bus.div_by_zero, bus.quotient, bus.remainder};
        checks++; if (!seen || got !== exp) begin errors++; $display("FAIL sweep_%0d_%0d got %h exp %h", a, b, got, exp); end
        if (b != 0) begin
          checks++;
          if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) || bus.remainder >= b) begin
            errors++; $display("FAIL sweep_invariant_%0d_%0d got q=%0d r=%0d exp q*d+r=dividend r<d", a, b, bus.quotient, bus.remainder);
          end
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
